// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures hs/vs timing on the pixel strobe, locks onto the
// expected raster and rebuilds DrawX/DrawY/de plus a blank-mismatch count.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_OFFSET    = 144,
  parameter int V_OFFSET    = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        de,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t      r_state, w_state_nx;
  logic        r_hs_q, r_vs_q, r_blank_q, r_line_seen, r_frame_bad, w_frame_bad_nx;
  logic [10:0] r_hcnt, w_hcnt_nx;
  logic [9:0]  r_vcnt, w_vcnt_nx, w_dx, w_dy;
  logic [2:0]  r_good, w_good_nx;
  logic        w_hfall, w_vfall, w_bad_line, w_vcnt_ok, w_lock_nx, w_vis;

  assign w_hfall    = pix_en & r_hs_q & ~hs;
  assign w_vfall    = pix_en & r_vs_q & ~vs;
  // the partial line seen right after reset is never judged
  assign w_bad_line = w_hfall & r_line_seen & (({1'b0, r_hcnt} + 12'd1) != 12'(H_TOTAL));
  assign w_vcnt_ok  = r_vcnt == 10'(V_TOTAL);
  assign w_hcnt_nx  = w_hfall ? '0 : (pix_en && r_hcnt != '1) ? r_hcnt + 11'd1 : r_hcnt;
  // a vfall coinciding with an hfall clears vcnt and swallows that line
  assign w_vcnt_nx  = w_vfall ? '0 : (w_hfall && r_vcnt != '1) ? r_vcnt + 10'd1 : r_vcnt;

  always_comb begin
    w_state_nx     = r_state;
    w_good_nx      = r_good;
    w_frame_bad_nx = r_frame_bad;
    if (r_state == SEARCH) begin
      w_good_nx      = '0;
      w_frame_bad_nx = 1'b0;
      w_state_nx     = w_vfall ? MEASURE : SEARCH;
    end else if (r_state == MEASURE) begin
      if (w_vfall) begin
        w_frame_bad_nx = 1'b0;
        w_good_nx      = (r_frame_bad | w_bad_line | ~w_vcnt_ok) ? '0 : r_good + 3'd1;
        w_state_nx     = (!(r_frame_bad | w_bad_line | ~w_vcnt_ok) &&
                          (r_good + 3'd1) == 3'(LOCK_FRAMES)) ? LOCKED : MEASURE;
      end else if (w_bad_line) begin
        w_frame_bad_nx = 1'b1;
      end
    end else if (w_bad_line | (w_vfall & ~w_vcnt_ok)) begin
      // the frame that broke lock must not count toward re-locking
      w_state_nx     = MEASURE;
      w_good_nx      = '0;
      w_frame_bad_nx = w_bad_line & ~w_vfall;
    end
  end

  assign w_lock_nx = w_state_nx == LOCKED;
  assign w_vis     = w_lock_nx &&
                     w_hcnt_nx >= 11'(H_OFFSET) && w_hcnt_nx < 11'(H_OFFSET + H_ACTIVE) &&
                     w_vcnt_nx >= 10'(V_OFFSET) && w_vcnt_nx < 10'(V_OFFSET + V_ACTIVE);
  assign w_dx      = w_hcnt_nx[9:0] - 10'(H_OFFSET);
  assign w_dy      = w_vcnt_nx - 10'(V_OFFSET);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= SEARCH;
      r_good      <= '0;
      r_frame_bad <= 1'b0;
      r_hs_q      <= 1'b1;
      r_vs_q      <= 1'b1;
      r_blank_q   <= 1'b0;
      r_line_seen <= 1'b0;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      locked      <= 1'b0;
      de          <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      err_count   <= '0;
    end else if (pix_en) begin
      r_state     <= w_state_nx;
      r_good      <= w_good_nx;
      r_frame_bad <= w_frame_bad_nx;
      r_hs_q      <= hs;
      r_vs_q      <= vs;
      r_blank_q   <= blank;
      r_line_seen <= r_line_seen | w_hfall;
      r_hcnt      <= w_hcnt_nx;
      r_vcnt      <= w_vcnt_nx;
      if (w_hfall) line_len <= r_hcnt + 11'd1;
      if (w_vfall) frame_lines <= r_vcnt;
      locked      <= w_lock_nx;
      de          <= w_vis;
      DrawX       <= w_vis ? w_dx : '0;
      DrawY       <= w_vis ? w_dy : '0;
      // r_blank_q and de describe the same earlier pixel
      if (locked && r_blank_q != de && err_count != '1) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed raster stimulus on a shrunken 40x20 timing
// so lock, loss of lock, saturation and async reset fit a short run.
module tb_vga_sync_decoder;
  localparam int HT = 40, VT = 20, HO = 8, VO = 3, HA = 24, VA = 12;
  localparam int HSW = 4, VSP = 20;

  logic        Clk = 1'b0, Reset_n = 1'b0, pix_en = 1'b0, hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [9:0]  DrawX, DrawY, frame_lines;
  logic        de, locked;
  logic [10:0] line_len;
  logic [7:0]  err_count;

  int total = 0, bad = 0, force_left = 0;
  logic hs_stuck = 1'b0;
  logic [9:0] s_x, s_y, s_fl;
  logic s_de, s_lk;
  logic [10:0] s_ll;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .hs(hs), .vs(vs), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .de(de), .locked(locked), .line_len(line_len),
    .frame_lines(frame_lines), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pixel(input logic h, input logic v, input logic b);
    @(posedge Clk); #1;
    pix_en = 1'b1; hs = h; vs = v; blank = b;
    @(posedge Clk); #1;
    pix_en = 1'b0;
  endtask

  // line d of a frame; vs falls mid-line 0 so it never coincides with an hfall
  task automatic line(input int d, input int len, input int pl, input int pp);
    logic v, b, vis;
    for (int p = 0; p < len; p++) begin
      v   = !((d == 0 && p >= VSP) || d == 1 || (d == 2 && p < VSP));
      vis = p >= HO && p < HO + HA && d >= VO && d < VO + VA;
      b   = vis;
      if (vis && force_left > 0) begin
        b = 1'b0;
        force_left--;
      end
      pixel(hs_stuck | (p >= HSW), v, b);
      if (d == pl && p == pp) begin
        s_x = DrawX; s_y = DrawY; s_de = de; s_lk = locked; s_ll = line_len; s_fl = frame_lines;
      end
    end
  endtask

  task automatic frame(input int nl, input int sl, input int pl, input int pp);
    for (int d = 0; d < nl; d++) line(d, d == sl ? HT - 1 : HT, pl, pp);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_drawx", 32'(DrawX), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_line_len", 32'(line_len), 0);
    chk("rst_err", 32'(err_count), 0);
    Reset_n = 1'b1;

    frame(VT, -1, -1, -1);
    frame(VT, -1, -1, -1);
    chk("pre_lock", 32'(locked), 0);
    frame(VT, -1, 0, 20);
    chk("lock_at_3rd_vfall", 32'(s_lk), 1);
    chk("line_len_std", 32'(line_len), 40);
    chk("frame_lines_std", 32'(frame_lines), 20);

    frame(VT, -1, 3, 8);
    chk("first_px_x", 32'(s_x), 0);
    chk("first_px_y", 32'(s_y), 0);
    chk("first_px_de", 32'(s_de), 1);
    frame(VT, -1, 14, 31);
    chk("last_px_x", 32'(s_x), 23);
    chk("last_px_y", 32'(s_y), 11);
    chk("last_px_de", 32'(s_de), 1);
    frame(VT, -1, 14, 32);
    chk("past_edge_de", 32'(s_de), 0);
    chk("past_edge_x", 32'(s_x), 0);
    chk("clean_err", 32'(err_count), 0);

    frame(VT, 5, 6, 0);
    chk("short_line_len", 32'(s_ll), 39);
    chk("short_unlock", 32'(s_lk), 0);
    chk("line_len_back", 32'(line_len), 40);
    frame(VT, -1, -1, -1);
    frame(VT, -1, -1, -1);
    chk("relock_not_early", 32'(locked), 0);
    frame(VT, -1, 0, 20);
    chk("relock", 32'(s_lk), 1);

    frame(VT - 1, -1, -1, -1);
    chk("short_frame_still_locked", 32'(locked), 1);
    frame(VT, -1, 0, 20);
    chk("short_frame_unlock", 32'(s_lk), 0);
    chk("short_frame_lines", 32'(s_fl), 19);
    frame(VT, -1, -1, -1);
    frame(VT, -1, -1, -1);
    chk("relock2", 32'(locked), 1);

    force_left = 10;
    frame(VT, -1, -1, -1);
    chk("err_10", 32'(err_count), 10);
    force_left = 300;
    frame(VT, -1, -1, -1);
    frame(VT, -1, -1, -1);
    chk("err_sat", 32'(err_count), 255);

    for (int d = 0; d < 5; d++) line(d, HT, -1, -1);
    line(5, 10, -1, -1);
    chk("pre_rst_locked", 32'(locked), 1);
    chk("pre_rst_x", 32'(DrawX), 1);
    chk("pre_rst_y", 32'(DrawY), 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_x", 32'(DrawX), 0);
    chk("async_y", 32'(DrawY), 0);
    chk("async_de", 32'(de), 0);
    chk("async_locked", 32'(locked), 0);
    chk("async_line_len", 32'(line_len), 0);
    chk("async_frame_lines", 32'(frame_lines), 0);
    chk("async_err", 32'(err_count), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    hs_stuck = 1'b1;
    repeat (4) frame(VT, -1, -1, -1);
    chk("stuck_no_lock", 32'(locked), 0);
    chk("stuck_line_len", 32'(line_len), 0);
    chk("stuck_frame_lines", 32'(frame_lines), 0);
    hs_stuck = 1'b0;
    frame(VT, -1, -1, -1);
    frame(VT, -1, -1, -1);
    chk("resume_not_early", 32'(locked), 0);
    frame(VT, -1, -1, -1);
    chk("resume_lock", 32'(locked), 1);
    chk("resume_line_len", 32'(line_len), 40);
    chk("resume_frame_lines", 32'(frame_lines), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the team's VGA timing generator (vga_controller).
- Consumes the hs/vs/blank stream plus the 25 MHz pixel strobe, measures line and frame timing, and locks onto 640x480@60.
- Reconstructs DrawX/DrawY and a data-enable, and counts blank-vs-decoded disagreements.
- Used in the on-chip video self-check path and as the bench monitor for any video source.

Parameters:
- H_TOTAL, 800: pixel periods per line.
- V_TOTAL, 525: lines per frame.
- H_OFFSET, 144: hcnt value of pixel X=0. hcnt is 0 at the hs falling edge; sync 96 + back porch 48.
- V_OFFSET, 35: vcnt value of row Y=0.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- LOCK_FRAMES, 2: consecutive good frames required to lock (1..7).

Ports:
- Clk, input, 1: 50 MHz system clock.
- Reset_n, input, 1: asynchronous active-low reset.
- pix_en, input, 1: one-Clk pixel strobe (every 2nd Clk). All sampling and counting happen only on cycles where pix_en=1.
- hs, input, 1: horizontal sync, active low.
- vs, input, 1: vertical sync, active low.
- blank, input, 1: source blanking, active low (1 = visible).
- DrawX, output, 10: reconstructed column.
- DrawY, output, 10: reconstructed row.
- de, output, 1: decoded visible pixel.
- locked, output, 1: timing lock.
- line_len, output, 11: last measured line length.
- frame_lines, output, 10: last measured lines per frame.
- err_count, output, 8: saturating blank-mismatch count.

Behaviour:
Reset values:
- All outputs 0.
- hs_q = vs_q = 1; hcnt = vcnt = 0; good = 0; line_seen = 0; frame_bad = 0; state = SEARCH.

Edge detection (on pix_en):
- hfall = pix_en & hs_q & ~hs; vfall = pix_en & vs_q & ~vs.
- hs_q and vs_q update only on pix_en.

Horizontal counter:
- On hfall: line_len <= hcnt + 1, hcnt <= 0, line_seen <= 1.
- Else on pix_en: hcnt <= hcnt + 1, saturating at 2047.

Vertical counter:
- On hfall: vcnt <= vcnt + 1, saturating at 1023.
- On vfall: frame_lines <= vcnt, vcnt <= 0.
- hfall and vfall in the same cycle: vfall wins; the vcnt clear takes priority and that hfall is not counted.

Line check:
- Applies at hfall when line_seen is already 1 (the first partial line after reset is never checked).
- bad_line = (hcnt + 1 != H_TOTAL).

FSM (state is SEARCH, MEASURE or LOCKED):
- SEARCH: on vfall -> MEASURE; good = 0; frame_bad = 0.
- MEASURE:
  - bad_line sets frame_bad.
  - On vfall, if frame_bad or vcnt != V_TOTAL: good = 0, frame_bad = 0, stay in MEASURE.
  - On vfall otherwise: good++. If good + 1 == LOCK_FRAMES -> LOCKED.
- LOCKED:
  - bad_line, or vfall with vcnt != V_TOTAL -> MEASURE with good = 0; locked drops the next Clk.
  - An hs or vs stuck high gives hcnt or vcnt saturation, hence a bad line or frame, hence loss of lock.
- locked = (state == LOCKED), registered.

Outputs:
- Registered; update one Clk after each pix_en cycle and hold between strobes.
- vis = locked & H_OFFSET <= hcnt < H_OFFSET + H_ACTIVE & V_OFFSET <= vcnt < V_OFFSET + V_ACTIVE. Evaluated on the post-update counter values.
- de = vis.
- DrawX = vis ? hcnt - H_OFFSET : 0.
- DrawY = vis ? vcnt - V_OFFSET : 0.
- Arithmetic is unsigned and truncated to 10 bits.

Error count:
- On pix_en while locked, if blank != de (one sample delay-matched by registering blank alongside), err_count++ saturating at 255.
- Cleared only by reset.

Reset mid-frame: everything returns to reset values immediately; re-lock needs a vfall plus LOCK_FRAMES good frames.

Test Plan:
- Reset, then 3 frames of standard 800x525 timing from vga_controller -> locked rises at the 3rd vfall (after 2 good frames); line_len = 800; frame_lines = 525.
- While locked, sample pixel hc=0 of line 0 -> DrawX = 0, DrawY = 0, de = 1. Sample hc=639 of line 479 -> DrawX = 639, DrawY = 479. Sample hc=640 -> de = 0, DrawX = 0.
- Locked, then one line shortened to 799 -> line_len = 799; locked = 0 one Clk after that hfall; re-lock 2 full good frames later.
- Locked, then a frame of 524 lines -> locked drops at that vfall; frame_lines = 524.
- Locked, with blank forced low for 10 visible pixels -> err_count = 10. Forced for 300 pixels -> err_count saturates at 255.
- Reset_n asserted mid-line while locked -> all outputs 0 asynchronously. hs held high after release -> hcnt saturates at 2047 and no lock ever occurs.
